// File: rtl/card_pair_matcher_pkg.sv
// rtl/card_pair_matcher_pkg.sv - shared card codes, address width and game FSM states
// Purpose: common definitions for the pair-matching game core and its helpers.
// Contents: card state codes, card address width, game state enum, board address check.
package card_pair_matcher_pkg;

  localparam int CARD_ADDR_W = 4;

  // Per-card state codes; 2'b10 is never produced.
  localparam logic [1:0] CARD_EMPTY = 2'b00;
  localparam logic [1:0] CARD_DOWN  = 2'b01;
  localparam logic [1:0] CARD_UP    = 2'b11;

  typedef enum logic [2:0] {
    ST_WAIT_START,
    ST_IDLE,
    ST_ONE_UP,
    ST_SHOW,
    ST_RESOLVE,
    ST_DONE
  } game_state_t;

  // Address 0 means "no card"; valid board addresses are 1..num_cards.
  function automatic logic addr_on_board(input logic [CARD_ADDR_W-1:0] addr,
                                         input int num_cards);
    return (addr != '0) && (int'(addr) <= num_cards);
  endfunction

endpackage

// File: rtl/card_pair_matcher_display_delay_timer.sv
// rtl/card_pair_matcher_display_delay_timer.sv - face-up display delay counter
// Purpose: counts the cycles both revealed cards stay visible.
// Ports: clk, rst (sync, active-high); start clears the count; run enables counting;
//        done is high in the last run cycle (count == DISPLAY_CYCLES-1).
module display_delay_timer #(
  parameter int DISPLAY_CYCLES = 65_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic done
);

  localparam int TW = (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(DISPLAY_CYCLES - 1);

  logic [TW-1:0] count;

  // Holds at LAST instead of wrapping; start always wins so an abandoned
  // delay never leaks into the next turn.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      count <= '0;
    end else if (run && (count != LAST)) begin
      count <= count + TW'(1);
    end
  end

  assign done = run && (count == LAST);

endmodule

// File: rtl/card_pair_matcher.sv
// rtl/card_pair_matcher.sv - game-state core for the 12-card pair matching board
// Purpose: holds per-card state, answers the click checker's state lookup, consumes
//          validated clicks, reveals two cards, holds them for a display delay, then
//          removes a matched pair or flips a mismatch back.
// Ports: clk, rst (sync, active-high); new_game + card_layout start a game;
//        card_to_test_address -> card_test_state (combinational lookup);
//        event_occurred + card_clicked_address are validated clicks;
//        click_enable, card_state_flat, pairs_found, match_pulse, mismatch_pulse,
//        game_over, move_count are registered status outputs.
// Build option: define MOVE_COUNTER_EN to enable the saturating move_count; otherwise
//        move_count is tied to zero.
module card_pair_matcher
  import card_pair_matcher_pkg::*;
#(
  parameter int NUM_CARDS      = 12,
  parameter int PAIR_ID_W      = 4,
  parameter int DISPLAY_CYCLES = 65_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           new_game,
  input  logic [NUM_CARDS*PAIR_ID_W-1:0] card_layout,
  input  logic [CARD_ADDR_W-1:0]         card_to_test_address,
  output logic [1:0]                     card_test_state,
  input  logic                           event_occurred,
  input  logic [CARD_ADDR_W-1:0]         card_clicked_address,
  output logic                           click_enable,
  output logic [2*NUM_CARDS-1:0]         card_state_flat,
  output logic [3:0]                     pairs_found,
  output logic                           match_pulse,
  output logic                           mismatch_pulse,
  output logic                           game_over,
  output logic [7:0]                     move_count
);

  game_state_t                    state;
  logic [1:0]                     cards [1:NUM_CARDS];
  logic [NUM_CARDS*PAIR_ID_W-1:0] layout_r;
  logic [CARD_ADDR_W-1:0]         first_addr;
  logic [CARD_ADDR_W-1:0]         second_addr;
  logic                           match_r;
  logic                           click_ok;
  logic                           second_ok;
  logic                           timer_done;

  // Mux-style lookup so out-of-board addresses read as empty without
  // indexing past the array.
  function automatic logic [1:0] card_at(input logic [CARD_ADDR_W-1:0] addr);
    logic [1:0] s;
    s = CARD_EMPTY;
    for (int n = 1; n <= NUM_CARDS; n++) begin
      if (int'(addr) == n) s = cards[n];
    end
    return s;
  endfunction

  function automatic logic [PAIR_ID_W-1:0] pair_id_of(input logic [CARD_ADDR_W-1:0] addr);
    logic [PAIR_ID_W-1:0] id;
    id = '0;
    for (int n = 1; n <= NUM_CARDS; n++) begin
      if (int'(addr) == n) id = layout_r[(n-1)*PAIR_ID_W +: PAIR_ID_W];
    end
    return id;
  endfunction

  assign card_test_state = card_at(card_to_test_address);

  // A click only counts on a face-down card that is on the board; this also
  // rejects re-clicking the first card, which is already face-up.
  assign click_ok  = event_occurred && addr_on_board(card_clicked_address, NUM_CARDS)
                     && (card_at(card_clicked_address) == CARD_DOWN);
  assign second_ok = !new_game && (state == ST_ONE_UP) && click_ok
                     && (card_clicked_address != first_addr);

  display_delay_timer #(
    .DISPLAY_CYCLES(DISPLAY_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .start(second_ok),
    .run  (state == ST_SHOW),
    .done (timer_done)
  );

  always_comb begin
    card_state_flat = '0;
    for (int n = 1; n <= NUM_CARDS; n++) begin
      card_state_flat[2*(n-1) +: 2] = cards[n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_WAIT_START;
      for (int n = 1; n <= NUM_CARDS; n++) cards[n] <= CARD_EMPTY;
      layout_r       <= '0;
      first_addr     <= '0;
      second_addr    <= '0;
      match_r        <= 1'b0;
      pairs_found    <= '0;
      match_pulse    <= 1'b0;
      mismatch_pulse <= 1'b0;
      game_over      <= 1'b0;
      click_enable   <= 1'b0;
    end else begin
      match_pulse    <= 1'b0;
      mismatch_pulse <= 1'b0;
      if (new_game) begin
        // Restart from any state; a click in the same cycle is dropped.
        state        <= ST_IDLE;
        for (int n = 1; n <= NUM_CARDS; n++) cards[n] <= CARD_DOWN;
        layout_r     <= card_layout;
        pairs_found  <= '0;
        game_over    <= 1'b0;
        click_enable <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (click_ok) begin
              cards[card_clicked_address] <= CARD_UP;
              first_addr                  <= card_clicked_address;
              state                       <= ST_ONE_UP;
            end
          end
          ST_ONE_UP: begin
            if (second_ok) begin
              cards[card_clicked_address] <= CARD_UP;
              second_addr                 <= card_clicked_address;
              match_r      <= (pair_id_of(first_addr) == pair_id_of(card_clicked_address));
              state        <= ST_SHOW;
              click_enable <= 1'b0;
            end
          end
          ST_SHOW: begin
            if (timer_done) state <= ST_RESOLVE;
          end
          ST_RESOLVE: begin
            if (match_r) begin
              cards[first_addr]  <= CARD_EMPTY;
              cards[second_addr] <= CARD_EMPTY;
              pairs_found        <= pairs_found + 4'd1;
              match_pulse        <= 1'b1;
            end else begin
              cards[first_addr]  <= CARD_DOWN;
              cards[second_addr] <= CARD_DOWN;
              mismatch_pulse     <= 1'b1;
            end
            if (match_r && (int'(pairs_found) + 1 == NUM_CARDS / 2)) begin
              state     <= ST_DONE;
              game_over <= 1'b1;
            end else begin
              state        <= ST_IDLE;
              click_enable <= 1'b1;
            end
          end
          default: begin
            // ST_WAIT_START and ST_DONE only leave on new_game.
          end
        endcase
      end
    end
  end

`ifdef MOVE_COUNTER_EN
  logic [7:0] move_count_r;

  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      move_count_r <= '0;
    end else if ((state == ST_RESOLVE) && (move_count_r != 8'hFF)) begin
      move_count_r <= move_count_r + 8'd1;
    end
  end

  assign move_count = move_count_r;
`else
  assign move_count = 8'h00;
`endif

endmodule

// File: tb/tb_card_pair_matcher.sv
// tb/tb_card_pair_matcher.sv - self-checking bench for card_pair_matcher
module tb_card_pair_matcher;

  localparam int D = 8;
  localparam int NC = 12;

  logic        clk;
  logic        rst;
  logic        new_game;
  logic [47:0] card_layout;
  logic [3:0]  card_to_test_address;
  logic [1:0]  card_test_state;
  logic        event_occurred;
  logic [3:0]  card_clicked_address;
  logic        click_enable;
  logic [23:0] card_state_flat;
  logic [3:0]  pairs_found;
  logic        match_pulse;
  logic        mismatch_pulse;
  logic        game_over;
  logic [7:0]  move_count;

  card_pair_matcher #(
    .NUM_CARDS(NC),
    .PAIR_ID_W(4),
    .DISPLAY_CYCLES(D)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .new_game            (new_game),
    .card_layout         (card_layout),
    .card_to_test_address(card_to_test_address),
    .card_test_state     (card_test_state),
    .event_occurred      (event_occurred),
    .card_clicked_address(card_clicked_address),
    .click_enable        (click_enable),
    .card_state_flat     (card_state_flat),
    .pairs_found         (pairs_found),
    .match_pulse         (match_pulse),
    .mismatch_pulse      (mismatch_pulse),
    .game_over           (game_over),
    .move_count          (move_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Game = list of revealed cards plus a countdown to the resolve edge.
  bit m_started, m_over, m_match, m_mis, checking;
  int m_card [1:NC];
  int m_id   [1:NC];
  int up_q[$];
  int wait_cnt;
  int m_pairs, m_moves;

  task automatic model_step();
    int a, b;
    if (rst) begin
      m_started = 0; m_over = 0; m_match = 0; m_mis = 0;
      for (int n = 1; n <= NC; n++) m_card[n] = 0;
      up_q.delete(); wait_cnt = 0; m_pairs = 0; m_moves = 0;
      return;
    end
    m_match = 0; m_mis = 0;
    if (new_game) begin
      for (int n = 1; n <= NC; n++) begin
        m_card[n] = 1;
        m_id[n]   = int'(card_layout[4*n-1 -: 4]);
      end
      up_q.delete(); wait_cnt = 0; m_pairs = 0; m_moves = 0;
      m_started = 1; m_over = 0;
    end else if (wait_cnt > 0) begin
      wait_cnt--;
      if (wait_cnt == 0) begin
        a = up_q[0]; b = up_q[1];
        if (m_id[a] == m_id[b]) begin
          m_card[a] = 0; m_card[b] = 0; m_pairs++; m_match = 1;
        end else begin
          m_card[a] = 1; m_card[b] = 1; m_mis = 1;
        end
        if (m_moves < 255) m_moves++;
        up_q.delete();
        if (m_pairs == NC / 2) m_over = 1;
      end
    end else if (m_started && !m_over && event_occurred) begin
      a = int'(card_clicked_address);
      if (a >= 1 && a <= NC && m_card[a] == 1) begin
        m_card[a] = 3;
        up_q.push_back(a);
        // Second reveal: D face-up cycles, resolve on the edge after that.
        if (up_q.size() == 2) wait_cnt = D + 1;
      end
    end
  endtask

  function automatic logic [23:0] model_flat();
    logic [23:0] f;
    f = '0;
    for (int n = 1; n <= NC; n++) f[2*n-2 +: 2] = 2'(m_card[n]);
    return f;
  endfunction

  function automatic logic [1:0] model_test(input logic [3:0] a);
    int i;
    i = int'(a);
    if (i >= 1 && i <= NC) return 2'(m_card[i]);
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    model_step();
    checking = 1;
    #1;
    chk("flat", 32'(card_state_flat), 32'(model_flat()));
    chk("test_state", 32'(card_test_state), 32'(model_test(card_to_test_address)));
    chk("click_enable", 32'(click_enable), 32'(m_started && !m_over && wait_cnt == 0));
    chk("pairs_found", 32'(pairs_found), 32'(m_pairs));
    chk("match_pulse", 32'(match_pulse), 32'(m_match));
    chk("mismatch_pulse", 32'(mismatch_pulse), 32'(m_mis));
    chk("game_over", 32'(game_over), 32'(m_over));
`ifdef MOVE_COUNTER_EN
    chk("move_count", 32'(move_count), 32'(m_moves));
`else
    chk("move_count", 32'(move_count), 32'h0);
`endif
  end

  // ---------------- stimulus ----------------
  int lay [1:NC];

  task automatic load_layout();
    for (int n = 1; n <= NC; n++) card_layout[4*n-1 -: 4] = 4'(lay[n]);
  endtask

  task automatic step(input bit ng, input bit ev, input int a);
    new_game             = ng;
    event_occurred       = ev;
    card_clicked_address = 4'(a);
    card_to_test_address = 4'($urandom_range(0, 15));
    @(negedge clk);
    new_game       = 1'b0;
    event_occurred = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask

  task automatic click(input int a);
    step(0, 1, a);
  endtask

  task automatic play_pair(input int a, input int b);
    click(a); click(b); idle(D + 1);
  endtask

  initial begin
    int t, j, r;
    checking = 0;
    rst = 1'b1; new_game = 1'b0; event_occurred = 1'b0;
    card_clicked_address = '0; card_to_test_address = '0; card_layout = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_flat", 32'(card_state_flat), 32'h0);
    chk("reset_click_enable", 32'(click_enable), 32'h0);
    chk("reset_pairs", 32'(pairs_found), 32'h0);
    chk("reset_game_over", 32'(game_over), 32'h0);

    // Fixed layout: ids 0,0,1,1,...,5,5
    for (int n = 1; n <= NC; n++) lay[n] = (n - 1) / 2;
    load_layout();
    step(1, 0, 0);
    card_to_test_address = 4'd3;
    #1;
    chk("deal_flat", 32'(card_state_flat), 32'h555555);
    chk("deal_click_enable", 32'(click_enable), 32'h1);
    chk("deal_test3", 32'(card_test_state), 32'h1);

    click(1); click(2);
    chk("two_up_flat", 32'(card_state_flat), 32'h55555F);
    chk("show_click_enable", 32'(click_enable), 32'h0);
    idle(D);
    chk("no_early_match", 32'(match_pulse), 32'h0);
    idle(1);
    chk("match_pulse", 32'(match_pulse), 32'h1);
    chk("match_flat", 32'(card_state_flat), 32'h555550);
    chk("match_pairs", 32'(pairs_found), 32'h1);
    idle(1);
    chk("match_pulse_1cyc", 32'(match_pulse), 32'h0);

    click(3); click(5); idle(D + 1);
    chk("mismatch_pulse", 32'(mismatch_pulse), 32'h1);
    chk("mismatch_flat", 32'(card_state_flat), 32'h555550);
    chk("mismatch_pairs", 32'(pairs_found), 32'h1);

    // Ignored clicks: removed card, repeat of first card, during SHOW, off-board
    click(1); click(7); click(7); click(8); click(9); click(0); click(13);
    chk("ignore_flat", 32'(card_state_flat), 32'h55F550);
    idle(D + 1);
    chk("ignore_pairs", 32'(pairs_found), 32'h2);

    // new_game mid-SHOW, with a simultaneous click that must be dropped
    click(9); click(10); idle(3);
    step(1, 1, 11);
    chk("abort_flat", 32'(card_state_flat), 32'h555555);
    chk("abort_pairs", 32'(pairs_found), 32'h0);
    idle(D + 3);

    for (int k = 1; k <= NC / 2; k++) play_pair(2 * k - 1, 2 * k);
    chk("done_game_over", 32'(game_over), 32'h1);
    chk("done_click_enable", 32'(click_enable), 32'h0);
    chk("done_pairs", 32'(pairs_found), 32'h6);
`ifdef MOVE_COUNTER_EN
    chk("done_moves", 32'(move_count), 32'h6);
`endif
    click(1); idle(2);
    step(1, 0, 0);
    chk("restart_click_enable", 32'(click_enable), 32'h1);
    chk("restart_pairs", 32'(pairs_found), 32'h0);
    chk("restart_game_over", 32'(game_over), 32'h0);

    // Randomized games: shuffled layouts, random clicks, occasional restarts
    for (int g = 0; g < 6; g++) begin
      for (int n = 1; n <= NC; n++) lay[n] = (n - 1) / 2;
      for (int n = NC; n > 1; n--) begin
        j = $urandom_range(1, n);
        t = lay[n]; lay[n] = lay[j]; lay[j] = t;
      end
      load_layout();
      step(1, 0, 0);
      for (int c = 0; c < 400; c++) begin
        r = $urandom_range(0, 99);
        if (r < 1) step(1, 0, 0);
        else if (r < 3) step(1, 1, $urandom_range(1, 12));
        else if (r < 45) click($urandom_range(0, 14));
        else idle(1);
      end
      // Finish the game by pairing cards from the known layout.
      step(1, 0, 0);
      for (int p = 0; p < NC / 2; p++) begin
        int a, b;
        a = 0; b = 0;
        for (int n = 1; n <= NC; n++) begin
          if (lay[n] == p) begin
            if (a == 0) a = n; else b = n;
          end
        end
        play_pair(a, b);
      end
      idle(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
